// File: rtl/uart_pkg.sv
// Shared UART types and default constants for the transmit and receive paths.
package uart_pkg;

  localparam int DEFAULT_WORD_SIZE      = 8;
  localparam int DEFAULT_CLOCKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A frame is in progress in every state except IDLE.
  function automatic logic state_is_busy(input tx_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side and line-side signals of the UART transmitter.
interface uart_transmitter_if
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
  logic [WORD_SIZE-1:0] DataIn;
  logic                 Load;
  logic                 BufferFull;
  logic                 Busy;
  logic                 TxD;

  modport master (
    output DataIn,
    output Load,
    input  BufferFull,
    input  Busy,
    input  TxD
  );

  modport slave (
    input  DataIn,
    input  Load,
    output BufferFull,
    output Busy,
    output TxD
  );
endinterface

// File: rtl/tx_holding_buffer.sv
// Single-entry holding register with an occupancy flag. A write is taken only
// while the flag is clear; a write while full is dropped silently.
module tx_holding_buffer
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 load_i,
  input  logic                 transfer_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] hold_o,
  output logic                 full_o
);

  logic                 full_q, full_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 accept;

  // Accept and transfer are mutually exclusive: one needs full clear, the other full set.
  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    accept = load_i & ~full_q;
    if (accept) begin
      full_d = 1'b1;
      hold_d = data_i;
    end else if (transfer_i) begin
      full_d = 1'b0;
    end
  end

  // Holding register and flag state.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end

  assign hold_o = hold_q;
  assign full_o = full_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: holding buffer feeding a framed serial shifter.
//
// state | meaning
// IDLE  | line high, waiting for a word in the holding buffer
// START | start bit (line low) for CLOCKS_PER_BIT cycles
// DATA  | WORD_SIZE data bits, LSB first, one per bit period
// STOP  | stop bit (line high); last cycle may chain straight into START
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic               Clock,
  input  logic               ResetN,
  uart_transmitter_if.slave  bus
);

  localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_SIZE - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;

  logic [WORD_SIZE-1:0] hold;
  logic                 full;
  logic                 bit_end;
  logic                 transfer;

  assign bit_end  = (baud_q == LAST_BAUD);
  assign transfer = full & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  tx_holding_buffer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_hold (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .load_i     (bus.Load),
    .transfer_i (transfer),
    .data_i     (bus.DataIn),
    .hold_o     (hold),
    .full_o     (full)
  );

  // Next-state, counters and shifter; TxD is derived from the next state so the line is registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (transfer) begin
          state_d = START;
          shift_d = hold;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (transfer) begin
            state_d = START;
            shift_d = hold;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State, counter, shifter and line registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign bus.TxD        = txd_q;
  assign bus.Busy       = state_is_busy(state_q);
  assign bus.BufferFull = full;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: a frame-level model predicts flags and
// queues expected words; a line monitor decodes TxD frames and checks them.
module tb_uart_transmitter;

  localparam int WS    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (WS + 2) * CPB;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  uart_transmitter_if #(.WORD_SIZE(WS)) bus ();

  uart_transmitter #(
    .WORD_SIZE      (WS),
    .CLOCKS_PER_BIT (CPB)
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the buffer and the line.
  int          cyc = 0;
  bit          m_full = 1'b0;
  bit          m_busy = 1'b0;
  int          m_start = 0;
  logic [WS-1:0] m_hold = '0;
  logic [WS-1:0] exp_q[$];
  int          exp_t[$];

  // Model update on each active edge; a frame occupies FRAME cycles from its transfer edge.
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_full = 1'b0;
      m_busy = 1'b0;
      exp_q.delete();
      exp_t.delete();
    end else begin
      bit frame_done;
      cyc++;
      frame_done = m_busy && (cyc == m_start + FRAME);
      if (m_full && (!m_busy || frame_done)) begin
        m_start = cyc;
        m_busy  = 1'b1;
        m_full  = 1'b0;
        exp_q.push_back(m_hold);
        exp_t.push_back(cyc);
      end else begin
        if (frame_done) m_busy = 1'b0;
        if (bus.Load && !m_full) begin
          m_full = 1'b1;
          m_hold = bus.DataIn;
        end
      end
    end
  end

  // Line monitor and flag checks, sampled on the falling edge.
  bit   cap = 1'b0;
  int   n   = 0;
  int   t0  = 0;
  logic samples [FRAME];

  always @(negedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cap = 1'b0;
    end else begin
      chk1("BufferFull", bus.BufferFull, m_full);
      chk1("Busy", bus.Busy, m_busy);
      if (!m_busy) chk1("TxD_idle", bus.TxD, 1'b1);
      if (!cap && bus.TxD === 1'b0) begin
        cap = 1'b1;
        n   = 0;
        t0  = cyc;
      end
      if (cap) begin
        samples[n] = bus.TxD;
        n++;
        if (n == FRAME) begin
          bit            width_bad;
          logic [WS-1:0] word;
          cap       = 1'b0;
          width_bad = 1'b0;
          for (int b = 0; b < WS + 2; b++)
            for (int c = 1; c < CPB; c++)
              if (samples[b*CPB + c] !== samples[b*CPB]) width_bad = 1'b1;
          for (int b = 0; b < WS; b++) word[b] = samples[(b+1)*CPB];
          chk1("bit_width_ok", width_bad, 1'b0);
          chk1("start_bit", samples[0], 1'b0);
          chk1("stop_bit", samples[(WS+1)*CPB], 1'b1);
          chk1("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            chk("frame_word", int'(word), int'(exp_q.pop_front()));
            chk("frame_start_cycle", t0, exp_t.pop_front());
          end
        end
      end
    end
  end

  task automatic load(input logic [WS-1:0] d);
    bus.Load   = 1'b1;
    bus.DataIn = d;
    @(negedge Clock);
    bus.Load   = 1'b0;
  endtask

  task automatic wait_not_full();
    int i;
    for (i = 0; i < 200 && m_full; i++) @(negedge Clock);
    chk1("wait_full_drop_in_time", i < 200, 1'b1);
  endtask

  // Directed scenarios followed by random loads.
  initial begin
    bus.Load   = 1'b0;
    bus.DataIn = '0;
    ResetN     = 1'b0;
    repeat (2) @(negedge Clock);
    chk1("rst_TxD", bus.TxD, 1'b1);
    chk1("rst_BufferFull", bus.BufferFull, 1'b0);
    chk1("rst_Busy", bus.Busy, 1'b0);
    ResetN = 1'b1;
    repeat (50) @(negedge Clock);

    load(8'hA5);
    repeat (50) @(negedge Clock);

    load(8'h55);
    wait_not_full();
    load(8'h0F);
    repeat (90) @(negedge Clock);

    load(8'h3C);
    load(8'hFF);
    repeat (50) @(negedge Clock);
    load(8'h11);
    wait_not_full();
    load(8'h22);
    load(8'hFF);
    repeat (100) @(negedge Clock);

    load(8'h00);
    repeat (18) @(negedge Clock);
    chk1("pre_rst_TxD_data3", bus.TxD, 1'b0);
    #2 ResetN = 1'b0;
    #1;
    chk1("async_rst_TxD", bus.TxD, 1'b1);
    chk1("async_rst_Busy", bus.Busy, 1'b0);
    chk1("async_rst_BufferFull", bus.BufferFull, 1'b0);
    @(negedge Clock);
    ResetN = 1'b1;
    repeat (30) @(negedge Clock);

    load(8'h00);
    repeat (45) @(negedge Clock);
    load(8'hFF);
    repeat (45) @(negedge Clock);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.Load   = 1'b1;
        bus.DataIn = WS'($urandom);
      end else begin
        bus.Load = 1'b0;
      end
      @(negedge Clock);
    end
    bus.Load = 1'b0;
    repeat (100) @(negedge Clock);
    chk("queue_drained", exp_q.size(), 0);
    chk1("monitor_idle", cap, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
